uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Full-duplex 8N1 UART transceiver with independent TX and RX engines sharing one clock.
- TX serialises a parallel byte on a start strobe.
- RX deserialises the line into a byte and pulses a valid flag.
- Sits between the board serial pins and the data-memory/programmer logic, which drives serial_write_i and consumes serial_read_o.

Parameters:
- CLK_FREQ_HZ, 50000000: CLK_UART_i frequency.
- BAUD_RATE, 115200: line bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (434): clock cycles per bit. Minimum 4. Benches override it directly.

Ports:
- CLK_UART_i  in  1  system clock; all logic is rising-edge.
- RST_UART_ni  in  1  asynchronous active-low reset.
- serial_rx_i  in  1  asynchronous serial input line; idles high.
- start_tx_i  in  1  transmit request, level-sampled each clock.
- serial_write_i  in  8  byte to transmit; latched on accepted start.
- busy_rx_o  out  1  high while an RX frame is in progress.
- busy_tx_o  out  1  high while a TX frame is in progress.
- valid_rx_o  out  1  one-cycle pulse when a new byte is available.
- serial_tx_o  out  1  serial output line; idles high.
- serial_read_o  out  8  last correctly received byte.

Behaviour:
- Reset (async assert, sync-released by the environment) forces:
  - serial_tx_o=1, busy_tx_o=0, busy_rx_o=0, valid_rx_o=0, serial_read_o=8'h00.
  - Both FSMs to IDLE and all counters to 0.
- Reset mid-frame aborts the frame immediately. No partial byte is reported.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: serial_tx_o=1.
  - If start_tx_i=1 at a clock edge, latch serial_write_i into the shift register, set busy_tx_o=1 and enter START. serial_tx_o=0 from the next cycle.
  - Each state lasts exactly CLKS_PER_BIT cycles. DATA sends bits 0..7 using a 3-bit index.
  - After the STOP period, return to IDLE and set busy_tx_o=0.
  - Total busy time is 10*CLKS_PER_BIT cycles.
  - start_tx_i while busy_tx_o=1 is ignored. A change on serial_write_i during a frame has no effect.
  - start_tx_i held high continuously gives back-to-back frames: a new frame starts the cycle after busy_tx_o falls, with busy low for one cycle.
- RX FSM, states IDLE, START, DATA, STOP:
  - serial_rx_i passes through a 2-flop synchronizer before any use.
  - IDLE: a synchronized 0 enters START and sets busy_rx_o=1.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 1 it is a false start: return to IDLE and set busy_rx_o=0. If 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles (bit centre) into bits 0..7, LSB first.
  - STOP: sample at the stop-bit centre.
    - If 1: load serial_read_o, pulse valid_rx_o for exactly one cycle, return to IDLE, set busy_rx_o=0.
    - If 0 (framing error): discard the byte, no valid pulse, serial_read_o unchanged, and wait in IDLE for the line to return high before re-arming.
- serial_read_o holds its value until the next valid frame.
- valid_rx_o and busy_rx_o falling occur in the same cycle.
- TX and RX are fully independent. Loopback (serial_tx_o to serial_rx_i) must work concurrently.
- Counter widths are $clog2(CLKS_PER_BIT) bits. Counters never wrap mid-bit.

Decomposition:
- Package uart_pkg holds:
  - TX and RX state enums (IDLE/START/DATA/STOP).
  - Localparams DATA_BITS=8, IDLE_LEVEL=1'b1.
  - A function computing CLKS_PER_BIT.
- One natural sub-module: uart_sync2, the 2-flop input synchronizer with reset value 1. TX and RX FSMs stay in uart_core.

Test Plan:
- Reset with CLKS_PER_BIT=16 -> serial_tx_o=1, busy_tx_o=0, busy_rx_o=0, valid_rx_o=0, serial_read_o=8'h00.
- TX 8'hA5 with a 1-cycle start_tx_i -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; busy_tx_o high for 160 cycles. A second start_tx_i mid-frame is ignored.
- Drive an RX frame of 8'h3C -> busy_rx_o rises within 3 cycles of the start edge; a single valid_rx_o pulse occurs at the stop-bit centre; serial_read_o=8'h3C.
- Glitch on serial_rx_i low for 4 cycles -> false start; busy_rx_o returns to 0; no valid_rx_o pulse.
- RX frame 8'hFF with stop bit 0 -> no valid_rx_o pulse; serial_read_o keeps its prior value (8'h3C).
- Loopback sending 8'h00, 8'hFF, 8'h55 back-to-back -> each is received with exactly one valid_rx_o pulse. Assert RST_UART_ni mid-frame -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
// Holds the TX/RX state encodings and the bit-period helper.
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   function automatic int calc_clks_per_bit(
      input int clk_hz,
      input int baud
   );
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial input.
// Ports: clk, rst_n (async active-low), d (async in), q (synced out, resets high).
module uart_sync2
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= IDLE_LEVEL;
         q    <= IDLE_LEVEL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent TX and RX engines on one clock.
// Ports: CLK_UART_i, RST_UART_ni, serial_rx_i/serial_tx_o (line),
//   start_tx_i/serial_write_i/busy_tx_o (TX side),
//   serial_read_o/valid_rx_o/busy_rx_o (RX side).
module uart_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 50000000,
   parameter int BAUD_RATE    = 115200,
   parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE)
) (
   input  logic       CLK_UART_i,
   input  logic       RST_UART_ni,
   input  logic       serial_rx_i,
   input  logic       start_tx_i,
   input  logic [7:0] serial_write_i,
   output logic       busy_rx_o,
   output logic       busy_tx_o,
   output logic       valid_rx_o,
   output logic       serial_tx_o,
   output logic [7:0] serial_read_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

   // ---------------- TX ----------------
   tx_state_t      tx_state;
   logic [CW-1:0]  tx_cnt;
   logic [2:0]     tx_idx;
   logic [7:0]     tx_data;

   always_ff @(posedge CLK_UART_i or negedge RST_UART_ni) begin
      if (!RST_UART_ni) begin
         tx_state    <= TX_IDLE;
         tx_cnt      <= '0;
         tx_idx      <= '0;
         tx_data     <= '0;
         busy_tx_o   <= 1'b0;
         serial_tx_o <= IDLE_LEVEL;
      end else begin
         unique case (tx_state)
            TX_IDLE: begin
               serial_tx_o <= IDLE_LEVEL;
               tx_cnt      <= '0;
               tx_idx      <= '0;
               if (start_tx_i) begin
                  tx_data     <= serial_write_i;
                  busy_tx_o   <= 1'b1;
                  serial_tx_o <= 1'b0;
                  tx_state    <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt      <= '0;
                  serial_tx_o <= tx_data[0];
                  tx_state    <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_idx == IDX_LAST) begin
                     serial_tx_o <= IDLE_LEVEL;
                     tx_state    <= TX_STOP;
                  end else begin
                     tx_idx      <= tx_idx + 3'd1;
                     serial_tx_o <= tx_data[tx_idx + 3'd1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            TX_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt    <= '0;
                  busy_tx_o <= 1'b0;
                  tx_state  <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- RX ----------------
   logic           rx_s;
   rx_state_t      rx_state;
   logic [CW-1:0]  rx_cnt;
   logic [2:0]     rx_idx;
   logic [7:0]     rx_data;
   // Cleared after a framing error so a held-low line is not
   // mistaken for a fresh start bit.
   logic           rx_armed;

   uart_sync2 u_sync (
      .clk   (CLK_UART_i),
      .rst_n (RST_UART_ni),
      .d     (serial_rx_i),
      .q     (rx_s)
   );

   always_ff @(posedge CLK_UART_i or negedge RST_UART_ni) begin
      if (!RST_UART_ni) begin
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_idx        <= '0;
         rx_data       <= '0;
         rx_armed      <= 1'b1;
         busy_rx_o     <= 1'b0;
         valid_rx_o    <= 1'b0;
         serial_read_o <= '0;
      end else begin
         valid_rx_o <= 1'b0;
         unique case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_idx <= '0;
               if (!rx_armed) begin
                  rx_armed <= rx_s;
               end else if (!rx_s) begin
                  busy_rx_o <= 1'b1;
                  rx_state  <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  if (rx_s) begin
                     busy_rx_o <= 1'b0;
                     rx_state  <= RX_IDLE;
                  end else begin
                     rx_state <= RX_DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt          <= '0;
                  rx_data[rx_idx] <= rx_s;
                  rx_idx          <= rx_idx + 3'd1;
                  if (rx_idx == IDX_LAST) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt    <= '0;
                  busy_rx_o <= 1'b0;
                  rx_state  <= RX_IDLE;
                  if (rx_s) begin
                     serial_read_o <= rx_data;
                     valid_rx_o    <= 1'b1;
                  end else begin
                     rx_armed <= 1'b0;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core with CLKS_PER_BIT=16.
// RX bytes are scoreboarded; TX line is checked at bit centres.
module tb_uart_core;

   localparam int CPB = 16;

   logic       clk;
   logic       rst_n;
   logic       rx_in;
   logic       rx_line;
   logic       loop;
   logic       start_tx;
   logic [7:0] wr_data;
   logic       busy_rx;
   logic       busy_tx;
   logic       valid_rx;
   logic       tx_line;
   logic [7:0] rd_data;

   int n_cmp;
   int n_err;
   int n_exp;
   int n_valid;
   logic prev_valid;
   logic [7:0] sb[$];

   assign rx_in = loop ? tx_line : rx_line;

   uart_core #(
      .CLK_FREQ_HZ  (50000000),
      .BAUD_RATE    (115200),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .CLK_UART_i     (clk),
      .RST_UART_ni    (rst_n),
      .serial_rx_i    (rx_in),
      .start_tx_i     (start_tx),
      .serial_write_i (wr_data),
      .busy_rx_o      (busy_rx),
      .busy_tx_o      (busy_tx),
      .valid_rx_o     (valid_rx),
      .serial_tx_o    (tx_line),
      .serial_read_o  (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RX scoreboard: every valid pulse pops one expected byte.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_rx) begin
            n_valid++;
            chk("rx_busy_fall", 32'(busy_rx), 32'd0);
            if (prev_valid) chk("rx_double", 32'd1, 32'd0);
            if (sb.size() == 0) begin
               chk("rx_unexpected", 32'd1, 32'd0);
            end else begin
               chk("rx_byte", 32'(rd_data), 32'(sb.pop_front()));
            end
         end
         prev_valid <= valid_rx;
      end else begin
         prev_valid <= 1'b0;
      end
   end

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      int rise;
      rise = -1;
      if (stop) begin
         sb.push_back(b);
         n_exp++;
      end
      rx_line = 1'b0;
      for (int i = 1; i <= CPB; i++) begin
         @(negedge clk);
         if (rise < 0 && busy_rx) rise = i;
      end
      chk("rx_busy_rise", 32'(rise >= 1 && rise <= 3), 32'd1);
      for (int k = 0; k < 8; k++) begin
         rx_line = b[k];
         repeat (CPB) @(negedge clk);
      end
      rx_line = stop;
      repeat (CPB) @(negedge clk);
      rx_line = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic wait_tx(input logic lvl, input string tag);
      int n;
      n = 0;
      while (busy_tx !== lvl && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk(tag, 32'(busy_tx), 32'(lvl));
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] exp_line;
      n_cmp    = 0;
      n_err    = 0;
      n_exp    = 0;
      n_valid  = 0;
      rst_n    = 1'b0;
      rx_line  = 1'b1;
      loop     = 1'b0;
      start_tx = 1'b0;
      wr_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_tx",      32'(tx_line),  32'd1);
      chk("rst_busy_tx", 32'(busy_tx),  32'd0);
      chk("rst_busy_rx", 32'(busy_rx),  32'd0);
      chk("rst_valid",   32'(valid_rx), 32'd0);
      chk("rst_read",    32'(rd_data),  32'h00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // TX A5, one-cycle start, with an ignored mid-frame request
      exp_line = {1'b1, 8'hA5, 1'b0};
      wr_data  = 8'hA5;
      start_tx = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
      for (int k = 0; k <= 10 * CPB; k++) begin
         if (k % CPB == CPB / 2)
            chk($sformatf("tx_bit%0d", k / CPB), 32'(tx_line),
                32'(exp_line[k / CPB]));
         if (k == 100) begin
            start_tx = 1'b1;
            wr_data  = 8'h0F;
         end
         if (k == 101) start_tx = 1'b0;
         if (k == 10 * CPB - 1) chk("tx_busy_last", 32'(busy_tx), 32'd1);
         if (k == 10 * CPB)     chk("tx_busy_done", 32'(busy_tx), 32'd0);
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      chk("tx_idle_line", 32'(tx_line), 32'd1);
      chk("tx_idle_busy", 32'(busy_tx), 32'd0);

      // RX frame 3C
      rx_frame(8'h3C, 1'b1);
      chk("rx_read_3c", 32'(rd_data), 32'h3C);

      // glitch -> false start
      rx_line = 1'b0;
      repeat (3) @(negedge clk);
      chk("glitch_busy", 32'(busy_rx), 32'd1);
      @(negedge clk);
      rx_line = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_idle", 32'(busy_rx), 32'd0);

      // framing error: FF with stop 0
      rx_frame(8'hFF, 1'b0);
      chk("ferr_read", 32'(rd_data), 32'h3C);
      chk("ferr_busy", 32'(busy_rx), 32'd0);

      // loopback, back-to-back 00, FF, 55
      loop     = 1'b1;
      wr_data  = 8'h00;
      start_tx = 1'b1;
      sb.push_back(8'h00);
      n_exp++;
      wait_tx(1'b1, "lb_accept0");
      wr_data = 8'hFF;
      sb.push_back(8'hFF);
      n_exp++;
      wait_tx(1'b0, "lb_end0");
      wait_tx(1'b1, "lb_accept1");
      wr_data = 8'h55;
      sb.push_back(8'h55);
      n_exp++;
      wait_tx(1'b0, "lb_end1");
      wait_tx(1'b1, "lb_accept2");
      start_tx = 1'b0;
      wait_tx(1'b0, "lb_end2");
      repeat (30) @(negedge clk);
      chk("lb_read", 32'(rd_data), 32'h55);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("valid_count", 32'(n_valid), 32'(n_exp));

      // reset in the middle of a loopback frame
      wr_data  = 8'hA5;
      start_tx = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
      repeat (40) @(negedge clk);
      chk("mid_busy_tx", 32'(busy_tx), 32'd1);
      chk("mid_busy_rx", 32'(busy_rx), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tx",      32'(tx_line),  32'd1);
      chk("arst_busy_tx", 32'(busy_tx),  32'd0);
      chk("arst_busy_rx", 32'(busy_rx),  32'd0);
      chk("arst_valid",   32'(valid_rx), 32'd0);
      chk("arst_read",    32'(rd_data),  32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("post_rst_valid_count", 32'(n_valid), 32'(n_exp));
      chk("post_rst_busy_tx", 32'(busy_tx), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
